hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard/forwarding unit for the in-order pipeline. It tracks every in-flight register write from issue (E) through writeback as a shifting record of destination, remaining Tnew and captured result. It resolves the decode-stage read ports against that record, returning either forwarded data or a stall request. It replaces the per-stage fixed-width forwarding muxes with one block covering DEPTH downstream stages and NRD read ports.

## Interface
- DATA_W, 32: register data width
- ADDR_W, 5: register address width; address 0 is hardwired zero, never matched
- DEPTH, 3: tracked stages after decode (entry 0 = E, DEPTH-1 = W)
- NRD, 2: decode read ports
- TNEW_W, derived $clog2(DEPTH+1): width of tnew/tuse fields
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- iss_valid  in  1  decode instruction issues into E this cycle
- iss_we  in  1  issuing instruction writes a register
- iss_addr  in  ADDR_W  destination register
- iss_tnew  in  TNEW_W  cycles from entering E until result is produced
- res_valid  in  DEPTH  stage k presents its result this cycle
- res_data  in  DEPTH*DATA_W  stage k result, slice k
- rd_addr  in  NRD*ADDR_W  decode source registers
- rd_tuse  in  NRD*TNEW_W  cycles until each source is consumed
- fwd_hit  out  NRD  port i matched an in-flight write; use fwd_data
- fwd_data  out  NRD*DATA_W  forwarded value, valid when fwd_hit=1
- stall  out  1  hold F/D; bubble inserted into E
- stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Entry fields: valid, addr, tnew, data, dvalid. Reset: all fields 0; stall=0, fwd_hit=0, fwd_data=0, stall_cnt=0.
- Every clock the record shifts unconditionally: entry k+1 <= entry k; entry DEPTH-1 retires.
- Entry 0 loads {iss_valid & iss_we & !stall & iss_addr!=0, iss_addr, iss_tnew, 0, 0}; under stall it loads a bubble (valid=0) irrespective of iss_valid.
- tnew decrements on shift, saturating at 0.
- Data capture on shift: entry k+1.data <= res_valid[k] ? res_data[k] : entry k.data; dvalid likewise ORed.
- Lookup for port i: youngest (lowest k) valid entry with addr == rd_addr[i], rd_addr[i] != 0. Older matches are ignored.
- Hit: fwd_hit[i]=1; fwd_data = entry.dvalid ? entry.data : (res_valid[k] ? res_data[k] : 0).
- stall = OR over ports of (hit & entry.tnew > rd_tuse[i]). rd_tuse=0 with tnew=0 forwards, no stall.
- Hit with tnew==0, !dvalid and !res_valid[k] is a producer protocol error; fwd_data=0, simulation assertion fires.
- No match: fwd_hit=0, fwd_data=0; consumer reads the register file.

## Timing
- Lookup, fwd_hit, fwd_data and stall are combinational from state and rd_*/res_* inputs, same cycle; no internal path from stall to iss_*.
- Issue-to-lookup visibility: write issued in cycle n is matched from cycle n+1 (entry 0).
- Result visible to forwarding the same cycle res_valid[k] rises; stored from next cycle.
- Retirement: entry leaves after DEPTH cycles; register file must hold the value by then (W writes in same cycle it is entry DEPTH-1).
- Reset assertion mid-operation clears all entries immediately; first edge after release behaves as an empty pipeline.

## Configuration
- HAZARD_STATS_EN defined: stall_cnt increments each cycle stall=1, saturating at 32'hFFFF_FFFF, cleared only by reset.
- Undefined: counter logic not compiled; stall_cnt tied to 0. Port list identical either way.

## Structure
- Package hazard_pkg: entry struct/field widths, TNEW_W function, REG_ZERO constant.
- Sub-module hs_lookup: per-port priority match over DEPTH entries returning hit, index, data, need_stall; instantiated NRD times.

## Test plan
- Reset then rd_addr={5,6}, no issue -> fwd_hit=00, stall=0, stall_cnt=0.
- Issue $5 tnew=1, next cycle rd_addr[0]=5 tuse=0 -> stall=1 one cycle; following cycle res_valid[1]=1 data 0x1234 -> fwd_hit[0]=1, fwd_data=0x1234, stall=0.
- Issue $7 tnew=0 data 0xAA in E, then $7 tnew=0 data 0xBB -> lookup $7 returns 0xBB (youngest wins).
- Issue with iss_addr=0 or iss_we=0 -> later lookup of $0/that addr gives fwd_hit=0.
- Write $3 ages DEPTH cycles -> lookup hits through cycle DEPTH, fwd_hit=0 after retirement.
- With HAZARD_STATS_EN, force 4 stall cycles -> stall_cnt=4; without, stall_cnt=0; assert rst_n low mid-stall -> stall=0, all hits clear at once.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_pkg                                                           |
// | Shared types and helpers for the hazard/forwarding scoreboard:       |
// |   entry_flags_t - per-entry status bits (valid, dvalid)              |
// |   tnew_width()  - width of tnew/tuse fields for a given depth        |
// |   idx_width()   - width of an entry index for a given depth          |
// |   REG_ZERO      - hardwired-zero register, never tracked or matched  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package hazard_pkg;

  localparam int REG_ZERO = 0;

  // Status bits of one in-flight write. The destination, tnew and data
  // fields are parametrised per instance and live alongside these.
  typedef struct packed {
    logic valid;   // entry holds a real register write
    logic dvalid;  // result has been captured into the entry
  } entry_flags_t;

  // Enough bits to count 0..depth cycles.
  function automatic int tnew_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Entry index width, never zero.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hs_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hs_lookup                                                            |
// | Priority match of one decode read port against all tracked entries.  |
// | The youngest (lowest index) valid entry with a matching destination  |
// | wins; register 0 never matches.                                      |
// | Ports:                                                               |
// |   ent_valid/ent_dvalid/ent_addr/ent_tnew/ent_data - entry state      |
// |   res_valid/res_data - per-stage results presented this cycle        |
// |   rd_addr/rd_tuse    - source register and its consumption time      |
// |   hit/idx/data/need_stall - match result for this port               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module hs_lookup
  import hazard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int TNEW_W = tnew_width(DEPTH),
  parameter int IDX_W  = idx_width(DEPTH)
) (
  input  logic [DEPTH-1:0]        ent_valid,
  input  logic [DEPTH-1:0]        ent_dvalid,
  input  logic [DEPTH*ADDR_W-1:0] ent_addr,
  input  logic [DEPTH*TNEW_W-1:0] ent_tnew,
  input  logic [DEPTH*DATA_W-1:0] ent_data,
  input  logic [DEPTH-1:0]        res_valid,
  input  logic [DEPTH*DATA_W-1:0] res_data,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic [TNEW_W-1:0]       rd_tuse,
  output logic                    hit,
  output logic [IDX_W-1:0]        idx,
  output logic [DATA_W-1:0]       data,
  output logic                    need_stall
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit        = 1'b0;
    idx        = '0;
    data       = '0;
    need_stall = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent_valid[k] &&
          (ent_addr[k*ADDR_W +: ADDR_W] == rd_addr) &&
          (rd_addr != ADDR_W'(REG_ZERO))) begin
        hit  = 1'b1;
        idx  = IDX_W'(k);
        // Stored data first; otherwise bypass the result the stage is
        // producing right now; otherwise nothing is available yet.
        if (ent_dvalid[k])
          data = ent_data[k*DATA_W +: DATA_W];
        else if (res_valid[k])
          data = res_data[k*DATA_W +: DATA_W];
        else
          data = '0;
        need_stall = (ent_tnew[k*TNEW_W +: TNEW_W] > rd_tuse);
      end
    end
  end

endmodule : hs_lookup
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_scoreboard                                                    |
// | Tracks in-flight register writes from E to W as a shifting record    |
// | and resolves NRD decode read ports to forwarded data or a stall.     |
// | Ports:                                                               |
// |   clk, rst_n (async, active-low)                                     |
// |   iss_valid/iss_we/iss_addr/iss_tnew - instruction issuing into E    |
// |   res_valid/res_data - per-stage results, slice k for stage k        |
// |   rd_addr/rd_tuse    - decode source registers, slice i for port i   |
// |   fwd_hit/fwd_data   - per-port forwarding result                    |
// |   stall              - hold F/D, bubble into E                       |
// |   stall_cnt          - stall-cycle counter                           |
// | Build option: define HAZARD_STATS_EN to enable the stall counter;    |
// | otherwise stall_cnt is tied to zero.                                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int NRD    = 2,
  parameter int TNEW_W = tnew_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    iss_valid,
  input  logic                    iss_we,
  input  logic [ADDR_W-1:0]       iss_addr,
  input  logic [TNEW_W-1:0]       iss_tnew,
  input  logic [DEPTH-1:0]        res_valid,
  input  logic [DEPTH*DATA_W-1:0] res_data,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  input  logic [NRD*TNEW_W-1:0]   rd_tuse,
  output logic [NRD-1:0]          fwd_hit,
  output logic [NRD*DATA_W-1:0]   fwd_data,
  output logic                    stall,
  output logic [31:0]             stall_cnt
);

  localparam int IDX_W = idx_width(DEPTH);

  entry_flags_t [DEPTH-1:0] flags_q;
  logic [DEPTH*ADDR_W-1:0]  addr_q;
  logic [DEPTH*TNEW_W-1:0]  tnew_q;
  logic [DEPTH*DATA_W-1:0]  data_q;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_dvalid;
  logic [NRD-1:0]   need_stall;
  logic [NRD-1:0]   proto_err;

  always_comb begin
    ent_valid  = '0;
    ent_dvalid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ent_valid[k]  = flags_q[k].valid;
      ent_dvalid[k] = flags_q[k].dvalid;
    end
  end

  // Record shifts every cycle; a stalled decode inserts a bubble at E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      addr_q  <= '0;
      tnew_q  <= '0;
      data_q  <= '0;
    end else begin
      flags_q[0].valid  <= iss_valid & iss_we & ~stall &
                           (iss_addr != ADDR_W'(REG_ZERO));
      flags_q[0].dvalid <= 1'b0;
      addr_q[0 +: ADDR_W] <= iss_addr;
      tnew_q[0 +: TNEW_W] <= iss_tnew;
      data_q[0 +: DATA_W] <= '0;
      for (int k = 0; k < DEPTH - 1; k++) begin
        flags_q[k+1].valid  <= flags_q[k].valid;
        flags_q[k+1].dvalid <= flags_q[k].dvalid | res_valid[k];
        addr_q[(k+1)*ADDR_W +: ADDR_W] <= addr_q[k*ADDR_W +: ADDR_W];
        tnew_q[(k+1)*TNEW_W +: TNEW_W] <=
          (tnew_q[k*TNEW_W +: TNEW_W] == '0) ? '0
                                             : tnew_q[k*TNEW_W +: TNEW_W] - 1'b1;
        data_q[(k+1)*DATA_W +: DATA_W] <=
          res_valid[k] ? res_data[k*DATA_W +: DATA_W]
                       : data_q[k*DATA_W +: DATA_W];
      end
    end
  end

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_port
      logic [IDX_W-1:0]  port_idx;
      logic [TNEW_W-1:0] sel_tnew;

      hs_lookup #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TNEW_W (TNEW_W),
        .IDX_W  (IDX_W)
      ) u_lookup (
        .ent_valid  (ent_valid),
        .ent_dvalid (ent_dvalid),
        .ent_addr   (addr_q),
        .ent_tnew   (tnew_q),
        .ent_data   (data_q),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .rd_addr    (rd_addr[i*ADDR_W +: ADDR_W]),
        .rd_tuse    (rd_tuse[i*TNEW_W +: TNEW_W]),
        .hit        (fwd_hit[i]),
        .idx        (port_idx),
        .data       (fwd_data[i*DATA_W +: DATA_W]),
        .need_stall (need_stall[i])
      );

      // A producer that claims its result is ready (tnew==0) must either
      // have delivered it or be presenting it this cycle.
      assign sel_tnew     = tnew_q[int'(port_idx)*TNEW_W +: TNEW_W];
      assign proto_err[i] = fwd_hit[i] & (sel_tnew == '0) &
                            ~ent_dvalid[port_idx] & ~res_valid[port_idx];

      a_producer_ready : assert property (
        @(posedge clk) disable iff (!rst_n) !proto_err[i]);
    end
  endgenerate

  assign stall = |need_stall;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_scoreboard                                                 |
// | Directed self-checking bench for hazard_scoreboard (DEPTH=3, NRD=2). |
// | Inputs change 1 time unit after the rising edge; outputs are checked |
// | mid-cycle. HAZARD_STATS_EN selects the expected counter behaviour.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_hazard_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 3;
  localparam int NRD    = 2;
  localparam int TNEW_W = 2;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    iss_valid;
  logic                    iss_we;
  logic [ADDR_W-1:0]       iss_addr;
  logic [TNEW_W-1:0]       iss_tnew;
  logic [DEPTH-1:0]        res_valid;
  logic [DEPTH*DATA_W-1:0] res_data;
  logic [NRD*ADDR_W-1:0]   rd_addr;
  logic [NRD*TNEW_W-1:0]   rd_tuse;
  logic [NRD-1:0]          fwd_hit;
  logic [NRD*DATA_W-1:0]   fwd_data;
  logic                    stall;
  logic [31:0]             stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .NRD    (NRD),
    .TNEW_W (TNEW_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_we    (iss_we),
    .iss_addr  (iss_addr),
    .iss_tnew  (iss_tnew),
    .res_valid (res_valid),
    .res_data  (res_data),
    .rd_addr   (rd_addr),
    .rd_tuse   (rd_tuse),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    iss_we    = 1'b0;
    iss_addr  = '0;
    iss_tnew  = '0;
    res_valid = '0;
    res_data  = '0;
    rd_addr   = '0;
    rd_tuse   = '0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a, input logic [TNEW_W-1:0] t);
    iss_valid = 1'b1;
    iss_we    = 1'b1;
    iss_addr  = a;
    iss_tnew  = t;
  endtask

  task automatic flush();
    idle();
    repeat (DEPTH + 1) tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    rd_addr = {5'd6, 5'd5};
    #4;
    checks++;
    if (fwd_hit !== 2'b00) begin
      errors++; $display("FAIL reset_hit: got %b expected 00", fwd_hit);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", stall);
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
    checks++;
    if (fwd_data !== '0) begin
      errors++; $display("FAIL reset_fwd_data: got %h expected 0", fwd_data);
    end
    tick();
  endtask

  // $5 tnew=1 read with tuse=0 stalls one cycle, then forwards 0x1234
  // from stage 1. An issue attempted during the stall must be dropped.
  task automatic test_stall_forward();
    idle(); issue(5'd5, 2'd1);
    tick();
    idle(); issue(5'd9, 2'd0);
    rd_addr = {5'd0, 5'd5};
    #4;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL sf_stall: got %b expected 1", stall);
    end
    checks++;
    if (fwd_hit !== 2'b01) begin
      errors++; $display("FAIL sf_hit_early: got %b expected 01", fwd_hit);
    end
    tick();
    idle();
    rd_addr = {5'd9, 5'd5};
    res_valid = 3'b010;
    res_data[1*DATA_W +: DATA_W] = 32'h0000_1234;
    #4;
    checks++;
    if (fwd_hit !== 2'b01) begin
      errors++; $display("FAIL sf_hit: got %b expected 01", fwd_hit);
    end
    checks++;
    if (fwd_data[31:0] !== 32'h0000_1234) begin
      errors++; $display("FAIL sf_data_bypass: got %h expected 00001234", fwd_data[31:0]);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL sf_no_stall: got %b expected 0", stall);
    end
    tick();
    idle();
    rd_addr = {5'd0, 5'd5};
    #4;
    checks++;
    if (fwd_data[31:0] !== 32'h0000_1234 || fwd_hit !== 2'b01) begin
      errors++; $display("FAIL sf_data_stored: got hit %b data %h expected 01 00001234",
                         fwd_hit, fwd_data[31:0]);
    end
    flush();
  endtask

  task automatic test_youngest();
    idle(); issue(5'd7, 2'd0);
    tick();
    idle(); issue(5'd7, 2'd0);
    res_valid = 3'b001;
    res_data[DATA_W-1:0] = 32'h0000_00AA;
    rd_addr = {5'd0, 5'd7};
    #4;
    checks++;
    if (fwd_hit !== 2'b01 || fwd_data[31:0] !== 32'h0000_00AA) begin
      errors++; $display("FAIL young_first: got hit %b data %h expected 01 000000aa",
                         fwd_hit, fwd_data[31:0]);
    end
    tick();
    idle();
    res_valid = 3'b001;
    res_data[DATA_W-1:0] = 32'h0000_00BB;
    rd_addr = {5'd7, 5'd7};
    #4;
    checks++;
    if (fwd_data !== {32'h0000_00BB, 32'h0000_00BB}) begin
      errors++; $display("FAIL young_bypass: got %h expected both 000000bb", fwd_data);
    end
    tick();
    idle();
    rd_addr = {5'd0, 5'd7};
    #4;
    checks++;
    if (fwd_data[31:0] !== 32'h0000_00BB) begin
      errors++; $display("FAIL young_stored: got %h expected 000000bb", fwd_data[31:0]);
    end
    flush();
  endtask

  task automatic test_no_write();
    idle();
    iss_valid = 1'b1; iss_we = 1'b0; iss_addr = 5'd8;
    tick();
    idle(); issue(5'd0, 2'd0);
    rd_addr = {5'd0, 5'd8};
    #4;
    checks++;
    if (fwd_hit !== 2'b00) begin
      errors++; $display("FAIL nowrite_we0: got %b expected 00", fwd_hit);
    end
    tick();
    idle();
    rd_addr = {5'd8, 5'd0};
    #4;
    checks++;
    if (fwd_hit !== 2'b00 || fwd_data !== '0) begin
      errors++; $display("FAIL nowrite_zero: got hit %b data %h expected 00 0",
                         fwd_hit, fwd_data);
    end
    flush();
  endtask

  task automatic test_retire();
    idle(); issue(5'd3, 2'd0);
    tick();
    for (int c = 1; c <= DEPTH + 1; c++) begin
      idle();
      if (c == 1) begin
        res_valid = 3'b001;
        res_data[DATA_W-1:0] = 32'h0000_0033;
      end
      rd_addr = {5'd3, 5'd0};
      #4;
      checks++;
      if (c <= DEPTH) begin
        if (fwd_hit !== 2'b10 || fwd_data[63:32] !== 32'h0000_0033) begin
          errors++; $display("FAIL retire_age%0d: got hit %b data %h expected 10 00000033",
                             c, fwd_hit, fwd_data[63:32]);
        end
      end else begin
        if (fwd_hit !== 2'b00 || fwd_data !== '0) begin
          errors++; $display("FAIL retire_gone: got hit %b data %h expected 00 0",
                             fwd_hit, fwd_data);
        end
      end
      tick();
    end
    flush();
  endtask

  task automatic test_stats();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    issue(5'd5, 2'd3);
    tick();
    for (int c = 0; c < 3; c++) begin
      idle();
      rd_addr = {5'd0, 5'd5};
      #4;
      checks++;
      if (stall !== 1'b1) begin
        errors++; $display("FAIL stats_stall%0d: got %b expected 1", c, stall);
      end
      tick();
    end
    idle(); issue(5'd6, 2'd1);
    tick();
    idle();
    rd_addr = {5'd6, 5'd0};
    #4;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL stats_stall3: got %b expected 1", stall);
    end
    tick();
    idle();
    #4;
    checks++;
    if (stall_cnt !== (STATS ? 32'd4 : 32'd0)) begin
      errors++; $display("FAIL stats_count: got %0d expected %0d",
                         stall_cnt, STATS ? 4 : 0);
    end
    flush();
  endtask

  task automatic test_reset_mid();
    idle(); issue(5'd5, 2'd3);
    tick();
    idle();
    rd_addr = {5'd5, 5'd5};
    #2;
    checks++;
    if (stall !== 1'b1 || fwd_hit !== 2'b11) begin
      errors++; $display("FAIL midrst_pre: got stall %b hit %b expected 1 11", stall, fwd_hit);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_hit !== 2'b00 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL midrst_clear: got stall %b hit %b cnt %0d expected 0 00 0",
                         stall, fwd_hit, stall_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    #2;
    checks++;
    if (fwd_hit !== 2'b00 || stall !== 1'b0) begin
      errors++; $display("FAIL midrst_after: got hit %b stall %b expected 00 0", fwd_hit, stall);
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_stall_forward();
    test_youngest();
    test_no_write();
    test_retire();
    test_stats();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hazard_scoreboard
`default_nettype wire
